// File: rtl/multiplicador_pipe_if.sv
// Vector-in / result-out bundle of multiplicador_pipe. The master drives vectors
// and the slave returns results. Widths are derived from the same parameters as the engine.
interface multiplicador_pipe_if #(
  parameter int N_WORDS      = 12,
  parameter int NB_DATA      = 8,
  parameter int NB_ACC_EXTRA = 4
);
  localparam int N_PAIRS = (N_WORDS + 1) / 2;
  localparam int L       = $clog2(N_PAIRS);
  localparam int NB_SUM  = 2 * NB_DATA + L;
  localparam int NB_OUT  = NB_SUM + NB_ACC_EXTRA;

  logic [N_WORDS*NB_DATA-1:0] i_data;
  logic                       i_valid;
  logic                       i_acc_en;
  logic                       i_last;
  logic signed [NB_OUT-1:0]   o_data;
  logic                       o_valid;
  logic                       o_sat;

  modport master (
    output i_data, i_valid, i_acc_en, i_last,
    input  o_data, o_valid, o_sat
  );

  modport slave (
    input  i_data, i_valid, i_acc_en, i_last,
    output o_data, o_valid, o_sat
  );
endinterface

// File: rtl/multiplicador_pipe.sv
// Pipelined dot-product engine. It multiplies adjacent signed word pairs, reduces them in a registered
// adder tree and feeds the result into an optional saturating frame accumulator.
module multiplicador_pipe #(
  parameter int N_WORDS      = 12,
  parameter int NB_DATA      = 8,
  parameter int NB_ACC_EXTRA = 4
) (
  input  logic               clock,
  input  logic               reset,
  multiplicador_pipe_if.slave bus
);
  localparam int N_PAIRS = (N_WORDS + 1) / 2;
  localparam int L       = $clog2(N_PAIRS);
  localparam int NB_PROD = 2 * NB_DATA;
  localparam int NB_SUM  = NB_PROD + L;
  localparam int NB_OUT  = NB_SUM + NB_ACC_EXTRA;
  localparam int N_LEAF  = 1 << L;

  localparam logic signed [NB_OUT-1:0] ACC_MAX = {1'b0, {(NB_OUT-1){1'b1}}};
  localparam logic signed [NB_OUT-1:0] ACC_MIN = {1'b1, {(NB_OUT-1){1'b0}}};

  typedef struct packed {
    logic valid;
    logic acc_en;
    logic last;
  } side_t;

  typedef enum logic {IDLE, ACCUM} state_t;

  logic signed [NB_DATA-1:0] word [2*N_PAIRS];
  logic signed [NB_PROD-1:0] prod [N_PAIRS];
  logic signed [NB_SUM-1:0]  leaf [N_LEAF];

  // Heap-ordered tree: node n sums nodes 2n and 2n+1, leaves live at N_LEAF..2*N_LEAF-1.
  logic signed [NB_SUM-1:0]  node_q [1:2*N_LEAF-1];
  side_t                     side_q [0:L];

  // An odd word count gets a padding word of 1, so its last word passes through the multiply unchanged.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional write, so no latch is inferred.
    for (int k = 0; k < 2*N_PAIRS; k++) word[k] = NB_DATA'(1);
    for (int k = 0; k < N_WORDS; k++)   word[k] = bus.i_data[k*NB_DATA +: NB_DATA];
    for (int p = 0; p < N_LEAF; p++)    leaf[p] = '0;
    for (int p = 0; p < N_PAIRS; p++) begin
      prod[p] = NB_PROD'(word[2*p]) * NB_PROD'(word[2*p+1]);
      leaf[p] = NB_SUM'(prod[p]);
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: registers take non-blocking assignments so every stage samples the previous stage's old value.
    if (reset) begin
      // NOTE: the tree registers are cleared along with the valids, so a discarded vector leaves no residue.
      for (int n = 1; n < 2*N_LEAF; n++) node_q[n] <= '0;
      for (int k = 0; k <= L; k++)       side_q[k] <= '0;
    end else begin
      side_q[0] <= side_t'{valid: bus.i_valid, acc_en: bus.i_acc_en, last: bus.i_last};
      for (int k = 1; k <= L; k++)       side_q[k] <= side_q[k-1];
      for (int p = 0; p < N_LEAF; p++)   node_q[N_LEAF+p] <= leaf[p];
      for (int n = 1; n < N_LEAF; n++)   node_q[n] <= node_q[2*n] + node_q[2*n+1];
    end
  end

  // Stage A: single-shot pass-through or saturating frame accumulation.
  state_t                   state_q, state_d;
  logic signed [NB_OUT-1:0] acc_q, acc_d;
  logic                     sticky_q, sticky_d;
  logic signed [NB_OUT-1:0] data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     sat_q, sat_d;

  side_t                    side_a;
  logic signed [NB_OUT-1:0] tree_val;
  logic signed [NB_OUT-1:0] acc_cur;
  logic signed [NB_OUT:0]   sum;
  logic                     clamp;
  logic signed [NB_OUT-1:0] sat_sum;

  always_comb begin
    side_a   = side_q[L];
    tree_val = NB_OUT'(node_q[1]);
    acc_cur  = (state_q == ACCUM) ? acc_q : '0;
    sum      = {acc_cur[NB_OUT-1], acc_cur} + {tree_val[NB_OUT-1], tree_val};
    clamp    = sum[NB_OUT] ^ sum[NB_OUT-1];
    if (!clamp)           sat_sum = sum[NB_OUT-1:0];
    else if (sum[NB_OUT]) sat_sum = ACC_MIN;
    else                  sat_sum = ACC_MAX;

    state_d  = state_q;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    sat_d    = 1'b0;

    if (side_a.valid) begin
      if (!side_a.acc_en) begin
        data_d  = tree_val;
        valid_d = 1'b1;
      end else if (!side_a.last) begin
        acc_d    = sat_sum;
        sticky_d = sticky_q | clamp;
        state_d  = ACCUM;
      end else begin
        data_d   = sat_sum;
        valid_d  = 1'b1;
        sat_d    = sticky_q | clamp;
        acc_d    = '0;
        sticky_d = 1'b0;
        state_d  = IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      sat_q    <= sat_d;
    end
  end

  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
  assign bus.o_sat   = sat_q;
endmodule

// File: tb/tb_multiplicador_pipe.sv
// Scoreboard bench for multiplicador_pipe. It drives a 12-word and a 5-word instance with the same beats,
// and a plain arithmetic frame model predicts each result, its saturation flag and its arrival cycle.
module tb_multiplicador_pipe;
  localparam int NB_DATA      = 8;
  localparam int NB_ACC_EXTRA = 4;
  localparam int LAT12 = $clog2(6) + 2;
  localparam int LAT5  = $clog2(3) + 2;
  localparam int OUT12 = 2*NB_DATA + $clog2(6) + NB_ACC_EXTRA;
  localparam int OUT5  = 2*NB_DATA + $clog2(3) + NB_ACC_EXTRA;

  typedef struct {
    longint data;
    bit     sat;
    int     cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  multiplicador_pipe_if #(.N_WORDS(12), .NB_DATA(NB_DATA), .NB_ACC_EXTRA(NB_ACC_EXTRA)) bus12 ();
  multiplicador_pipe_if #(.N_WORDS(5),  .NB_DATA(NB_DATA), .NB_ACC_EXTRA(NB_ACC_EXTRA)) bus5 ();

  multiplicador_pipe #(.N_WORDS(12), .NB_DATA(NB_DATA), .NB_ACC_EXTRA(NB_ACC_EXTRA)) dut12 (
    .clock (clock),
    .reset (reset),
    .bus   (bus12)
  );

  multiplicador_pipe #(.N_WORDS(5), .NB_DATA(NB_DATA), .NB_ACC_EXTRA(NB_ACC_EXTRA)) dut5 (
    .clock (clock),
    .reset (reset),
    .bus   (bus5)
  );

  int     checks = 0;
  int     errors = 0;
  exp_t   q12[$];
  exp_t   q5[$];
  longint acc12 = 0, acc5 = 0;
  bit     sticky12 = 0, sticky5 = 0;
  longint last12 = 0, last5 = 0;
  int     w[12];

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Sum of adjacent-pair products over the first n words; an unpaired last word counts as itself.
  function automatic longint dot(input int n);
    longint s = 0;
    for (int i = 0; i < n; i += 2)
      s += (i + 1 < n) ? longint'(w[i]) * longint'(w[i+1]) : longint'(w[i]);
    return s;
  endfunction

  function automatic longint clamp_to(input longint v, input int nb, output bit clamped);
    longint hi = (longint'(1) <<< (nb - 1)) - 1;
    longint lo = -(longint'(1) <<< (nb - 1));
    clamped = (v > hi) || (v < lo);
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  function automatic void model(input longint t, input int nb, input bit e, input bit l,
                                inout longint acc, inout bit sticky,
                                output bit emit, output exp_t x);
    bit     c;
    longint s;
    emit = 1'b0;
    x    = '{data: 0, sat: 1'b0, cyc: cycle};
    if (!e) begin
      emit   = 1'b1;
      x.data = t;
    end else begin
      s = clamp_to(acc + t, nb, c);
      if (l) begin
        emit   = 1'b1;
        x.data = s;
        x.sat  = sticky | c;
        acc    = 0;
        sticky = 1'b0;
      end else begin
        acc    = s;
        sticky = sticky | c;
      end
    end
  endfunction

  task automatic drive(input bit v, input bit e, input bit l);
    bit   emit;
    exp_t x;
    @(negedge clock);
    for (int k = 0; k < 12; k++) bus12.i_data[k*NB_DATA +: NB_DATA] = NB_DATA'(w[k]);
    for (int k = 0; k < 5; k++)  bus5.i_data[k*NB_DATA +: NB_DATA]  = NB_DATA'(w[k]);
    bus12.i_valid = v; bus12.i_acc_en = e; bus12.i_last = l;
    bus5.i_valid  = v; bus5.i_acc_en  = e; bus5.i_last  = l;
    if (v && !reset) begin
      model(dot(12), OUT12, e, l, acc12, sticky12, emit, x);
      if (emit) q12.push_back(x);
      model(dot(5), OUT5, e, l, acc5, sticky5, emit, x);
      if (emit) q5.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic fill(input int a, input int b);
    for (int k = 0; k < 12; k++) w[k] = (k % 2 == 0) ? a : b;
  endtask

  // Holds reset for n cycles while offering a valid beat, which must be dropped.
  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    bus12.i_valid = 1'b1; bus12.i_acc_en = 1'b0;
    bus5.i_valid  = 1'b1; bus5.i_acc_en  = 1'b0;
    @(posedge clock);
    #1;
    q12.delete(); q5.delete();
    acc12 = 0; acc5 = 0; sticky12 = 0; sticky5 = 0; last12 = 0; last5 = 0;
    repeat (n - 1) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    bus12.i_valid = 1'b0;
    bus5.i_valid  = 1'b0;
  endtask

  always @(negedge clock) begin
    exp_t x;
    if (bus12.o_valid === 1'b1) begin
      if (q12.size() == 0) check("spurious o_valid n12", bus12.o_valid, 0);
      else begin
        x = q12.pop_front();
        check("o_data n12", bus12.o_data, x.data);
        check("o_sat n12", bus12.o_sat, x.sat);
        check("latency n12", cycle - x.cyc, LAT12);
        last12 = x.data;
      end
    end else check("o_data hold n12", bus12.o_data, last12);

    if (bus5.o_valid === 1'b1) begin
      if (q5.size() == 0) check("spurious o_valid n5", bus5.o_valid, 0);
      else begin
        x = q5.pop_front();
        check("o_data n5", bus5.o_data, x.data);
        check("o_sat n5", bus5.o_sat, x.sat);
        check("latency n5", cycle - x.cyc, LAT5);
        last5 = x.data;
      end
    end else check("o_data hold n5", bus5.o_data, last5);
  end

  initial begin
    int mode;
    bit v, e, l;
    bus12.i_data = '0; bus12.i_valid = 1'b0; bus12.i_acc_en = 1'b0; bus12.i_last = 1'b0;
    bus5.i_data  = '0; bus5.i_valid  = 1'b0; bus5.i_acc_en  = 1'b0; bus5.i_last  = 1'b0;
    fill(0, 0);
    do_reset(3);

    @(negedge clock);
    check("reset o_valid", bus12.o_valid, 0);
    check("reset o_data", bus12.o_data, 0);
    check("reset o_sat", bus12.o_sat, 0);
    check("reset o_valid n5", bus5.o_valid, 0);

    // Single beats: all ones, then the odd-count vector [2,3,4,5,-7].
    fill(1, 1);
    drive(1, 0, 0);
    idle(6);
    fill(0, 0);
    w[0] = 2; w[1] = 3; w[2] = 4; w[3] = 5; w[4] = -7;
    drive(1, 0, 0);
    idle(6);

    // Back-to-back extremes.
    fill(-128, -128); drive(1, 0, 0);
    fill(127, -128);  drive(1, 0, 0);
    idle(6);

    // Three-beat frame with a bubble and a single-shot beat interleaved.
    fill(1, 1); drive(1, 1, 0);
    idle(1);
    fill(1, 1); drive(1, 0, 0);
    fill(2, 2); drive(1, 1, 0);
    fill(3, 3); drive(1, 1, 1);
    idle(6);

    // Saturating 43-beat frame, then the largest frame that still fits.
    fill(-128, -128);
    for (int i = 0; i < 43; i++) drive(1, 1, i == 42);
    for (int i = 0; i < 42; i++) drive(1, 1, i == 41);
    idle(6);

    // Reset mid-frame discards the open frame and anything in flight.
    fill(1, 1);
    for (int i = 0; i < 10; i++) drive(1, 1, 0);
    do_reset(2);
    fill(1, 1); drive(1, 1, 1);
    idle(6);

    // Random traffic with per-frame data modes to reach both saturation rails.
    mode = 0;
    for (int i = 0; i < 600; i++) begin
      case (mode)
        1:       fill(-128, -128);
        2:       fill(127, -128);
        3:       fill(127, 127);
        default: for (int k = 0; k < 12; k++) w[k] = $urandom_range(0, 255) - 128;
      endcase
      v = ($urandom_range(0, 9) < 8);
      e = ($urandom_range(0, 9) < 8);
      l = ($urandom_range(0, 29) == 0);
      drive(v, e, l);
      if (v && e && l) mode = $urandom_range(0, 3);
      if (i == 300) do_reset(1);
    end

    idle(LAT12 + 3);
    check("drain n12", q12.size(), 0);
    check("drain n5", q5.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
